// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the LC-3b memory responder: FSM states, bus-command
// values and the MDR reset value, plus the byte sign-extension helper.
package mem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam logic [15:0] MDR_RST = 16'h0000;

    function automatic logic [15:0] sext8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word-organised storage with one shared address: asynchronous read and a
// clocked write gated per byte lane.
module mem_array #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [1:0]           be_i,
    input  logic [15:0]          wdata_i,
    output logic [15:0]          rdata_o
);

    logic [15:0] mem_q [2**ADDR_BITS];

    // NOTE: the array has no reset; clearing it would need one write port per word.
    always_ff @(posedge clk) begin
        if (be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
        if (be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_ctrl.sv
// LC-3b memory-side responder: MAR/MDR, fixed-latency access FSM raising R,
// and the tri-state MDR gate with byte sign-extension.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = 5,
    parameter int ADDR_BITS   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic        data_size,
    input  logic        gate_mdr,
    output logic        ready,
    output logic        unaligned,
    output logic [15:0] out
);

    localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [15:0]          mar_q, mar_d;
    logic [15:0]          mdr_q, mdr_d;
    logic [ADDR_BITS-1:0] word_idx;
    logic [15:0]          rdata;
    logic [1:0]           wr_be;
    logic                 commit;
    logic [15:0]          out_val;

    // MAR bits above the array index alias; bit 0 only steers byte lanes.
    logic unused_mar_hi;
    assign unused_mar_hi = ^mar_q[15:ADDR_BITS+1];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mio_en) begin
                    if (MEM_LATENCY == 1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_BUSY: begin
                if (!mio_en)              state_d = ST_IDLE;
                else if (cnt_q == CNT_LAST) state_d = ST_DONE;
                else                      cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready     = (state_q == ST_DONE);
    assign word_idx  = mar_q[ADDR_BITS:1];
    assign unaligned = mio_en & data_size & mar_q[0];

    // A reset landing on the DONE edge must not leave a half-finished write behind.
    assign commit = ready & (r_w == RW_WRITE) & ~rst;

    always_comb begin
        wr_be = 2'b00;
        if (commit) begin
            if (data_size == SIZE_WORD) wr_be = 2'b11;
            else                        wr_be = mar_q[0] ? 2'b10 : 2'b01;
        end
    end

    assign mar_d = (ld_mar && state_q == ST_IDLE) ? bus : mar_q;

    always_comb begin
        mdr_d = mdr_q;
        if (ld_mdr) begin
            if (mio_en) begin
                if (ready) mdr_d = rdata;
            end else begin
                mdr_d = (data_size == SIZE_WORD) ? bus : {bus[7:0], bus[7:0]};
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mar_q   <= '0;
            mdr_q   <= MDR_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    mem_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk    (clk),
        .addr_i (word_idx),
        .be_i   (wr_be),
        .wdata_i(mdr_q),
        .rdata_o(rdata)
    );

    assign out_val = (data_size == SIZE_WORD) ? mdr_q
                   : sext8(mar_q[0] ? mdr_q[15:8] : mdr_q[7:0]);
    assign out     = gate_mdr ? out_val : 'z;

endmodule
